// File: rtl/sort_seq_ctrl.sv
// Bubble-sort sequencer for the sorter's data RAM: one read port, one write port, unsigned in-place swaps.
// Optional: define SORT_EARLY_EXIT_EN to end the sort after the first pass with no swaps.
module sort_seq_ctrl #(
   parameter int AWIDTH = 4,
   parameter int DWIDTH = 8
) (
   input  logic              clk_i,
   input  logic              arst_n_i,
   input  logic              start_i,
   input  logic [AWIDTH-1:0] len_i,
   output logic              rd_en_o,
   output logic [AWIDTH-1:0] rd_addr_o,
   input  logic [DWIDTH-1:0] rd_data_i,
   output logic              wr_en_o,
   output logic [AWIDTH-1:0] wr_addr_o,
   output logic [DWIDTH-1:0] wr_data_o,
   output logic              busy_o,
   output logic              sort_done_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_A, S_RD_B, S_CMP, S_WR_A, S_WR_B, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [AWIDTH-1:0]   idx_q, idx_d;
   logic [AWIDTH-1:0]   pass_end_q, pass_end_d;
   logic [DWIDTH-1:0]   a_q, a_d;
   logic [DWIDTH-1:0]   b_q, b_d;
   logic [AWIDTH-1:0]   idx_inc, pass_end_dec;
   logic                advance, early_exit;
`ifdef SORT_EARLY_EXIT_EN
   logic                swapped_q, swapped_d;
`endif

   assign idx_inc      = idx_q + 1'b1;
   assign pass_end_dec = pass_end_q - 1'b1;

`ifdef SORT_EARLY_EXIT_EN
   assign early_exit = ~swapped_q;
`else
   assign early_exit = 1'b0;
`endif

   // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      pass_end_d = pass_end_q;
      a_d        = a_q;
      b_d        = b_q;
      advance    = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
      swapped_d  = swapped_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               pass_end_d = len_i;
               idx_d      = '0;
`ifdef SORT_EARLY_EXIT_EN
               swapped_d  = 1'b0;
`endif
               state_d    = (len_i == '0) ? S_DONE : S_RD_A;
            end
         end
         S_RD_A: state_d = S_RD_B;
         S_RD_B: begin
            a_d     = rd_data_i;
            state_d = S_CMP;
         end
         S_CMP: begin
            // Strict compare: equal neighbours stay put, keeping the sort stable.
            if (a_q > rd_data_i) begin
               b_d       = rd_data_i;
`ifdef SORT_EARLY_EXIT_EN
               swapped_d = 1'b1;
`endif
               state_d   = S_WR_A;
            end else begin
               advance = 1'b1;
            end
         end
         S_WR_A:  state_d = S_WR_B;
         S_WR_B:  advance = 1'b1;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (advance) begin
         if (idx_inc < pass_end_q) begin
            idx_d   = idx_inc;
            state_d = S_RD_A;
         end else begin
            pass_end_d = pass_end_dec;
            idx_d      = '0;
`ifdef SORT_EARLY_EXIT_EN
            swapped_d  = 1'b0;
`endif
            state_d    = ((pass_end_dec == '0) || early_exit) ? S_DONE : S_RD_A;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         pass_end_q <= '0;
         a_q        <= '0;
         b_q        <= '0;
`ifdef SORT_EARLY_EXIT_EN
         swapped_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         pass_end_q <= pass_end_d;
         a_q        <= a_d;
         b_q        <= b_d;
`ifdef SORT_EARLY_EXIT_EN
         swapped_q  <= swapped_d;
`endif
      end
   end

   // Outputs depend on registered state only; nothing from the inputs reaches them combinationally.
   always_comb begin
      rd_en_o     = 1'b0;
      rd_addr_o   = '0;
      wr_en_o     = 1'b0;
      wr_addr_o   = '0;
      wr_data_o   = '0;
      busy_o      = (state_q != S_IDLE);
      sort_done_o = (state_q == S_DONE);
      case (state_q)
         S_RD_A: begin
            rd_en_o   = 1'b1;
            rd_addr_o = idx_q;
         end
         S_RD_B: begin
            rd_en_o   = 1'b1;
            rd_addr_o = idx_inc;
         end
         S_WR_A: begin
            wr_en_o   = 1'b1;
            wr_addr_o = idx_q;
            wr_data_o = b_q;
         end
         S_WR_B: begin
            wr_en_o   = 1'b1;
            wr_addr_o = idx_inc;
            wr_data_o = a_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Self-checking bench for sort_seq_ctrl: behavioural RAM, bubble-sort reference model and write/latency scoreboard.
// Build with or without +define+SORT_EARLY_EXIT_EN; the reference model follows the same macro.
module tb_sort_seq_ctrl;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int N  = 1 << AW;

   logic          clk_i = 1'b0;
   logic          arst_n_i;
   logic          start_i;
   logic [AW-1:0] len_i;
   logic          rd_en_o, wr_en_o, busy_o, sort_done_o;
   logic [AW-1:0] rd_addr_o, wr_addr_o;
   logic [DW-1:0] rd_data_i, wr_data_o;

   logic [DW-1:0] mem [N];
   logic [DW-1:0] exp_ram [N];

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t wq[$];
   int  lat_q[$];
   int  n_vec = 0;
   int  n_err = 0;

   always #5 clk_i = ~clk_i;

   sort_seq_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
      .clk_i       (clk_i),
      .arst_n_i    (arst_n_i),
      .start_i     (start_i),
      .len_i       (len_i),
      .rd_en_o     (rd_en_o),
      .rd_addr_o   (rd_addr_o),
      .rd_data_i   (rd_data_i),
      .wr_en_o     (wr_en_o),
      .wr_addr_o   (wr_addr_o),
      .wr_data_o   (wr_data_o),
      .busy_o      (busy_o),
      .sort_done_o (sort_done_o)
   );

   // RAM with one-cycle read latency; the bench preloads it through the same non-blocking path.
   always @(posedge clk_i) begin
      if (wr_en_o) mem[wr_addr_o] <= wr_data_o;
      if (rd_en_o) rd_data_i <= mem[rd_addr_o];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Each observed write is matched against the next one the reference model predicted.
   always @(negedge clk_i) begin
      if (arst_n_i && (rd_en_o || wr_en_o)) begin
         check("rd_wr_exclusive", 32'(rd_en_o & wr_en_o), 32'd0);
         if (wr_en_o) begin
            if (wq.size() == 0) begin
               check("unexpected_write", 32'd1, 32'd0);
            end else begin
               wr_t w;
               w = wq.pop_front();
               check("wr_addr", 32'(wr_addr_o), 32'(w.addr));
               check("wr_data", 32'(wr_data_o), 32'(w.data));
            end
         end
      end
   end

   // Reference bubble sort over the current RAM image; pushes expected writes and done latency.
   task automatic model(input int len);
      logic [DW-1:0] m [N];
      logic [DW-1:0] t;
      int            pe, cyc;
      bit            sw;
      m   = mem;
      cyc = 1;
      pe  = len;
      while (pe > 0) begin
         sw = 1'b0;
         for (int i = 0; i < pe; i++) begin
            cyc += 3;
            if (m[i] > m[i+1]) begin
               wq.push_back('{addr: AW'(i),     data: m[i+1]});
               wq.push_back('{addr: AW'(i + 1), data: m[i]});
               t      = m[i];
               m[i]   = m[i+1];
               m[i+1] = t;
               sw     = 1'b1;
               cyc   += 2;
            end
         end
         pe--;
`ifdef SORT_EARLY_EXIT_EN
         if (!sw) break;
`endif
      end
      lat_q.push_back(cyc);
      exp_ram = m;
   endtask

   task automatic load4(input logic [DW-1:0] a, b, c, d);
      @(negedge clk_i);
      mem[0] <= a; mem[1] <= b; mem[2] <= c; mem[3] <= d;
      @(negedge clk_i);
   endtask

   // Latency counts cycles after the edge that accepts start; cycle 1 is the first busy state.
   task automatic run_sort(input int len, input bit disturb, input string tag);
      int cyc, exp_lat;
      model(len);
      @(negedge clk_i);
      start_i = 1'b1;
      len_i   = AW'(len);
      @(negedge clk_i);
      start_i = 1'b0;
      cyc     = 1;
      check({tag, "_busy_first"}, 32'(busy_o), 32'd1);
      while (!sort_done_o && cyc < 1000) begin
         start_i = disturb && (cyc % 4 == 0);
         len_i   = disturb ? AW'(cyc) : AW'(len);
         @(negedge clk_i);
         cyc++;
      end
      start_i = 1'b0;
      check({tag, "_done_seen"}, 32'(sort_done_o), 32'd1);
      exp_lat = (lat_q.size() != 0) ? lat_q.pop_front() : -1;
      check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
      @(negedge clk_i);
      check({tag, "_done_pulse_1cyc"}, 32'(sort_done_o), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
      check({tag, "_writes_drained"}, 32'(wq.size()), 32'd0);
      for (int i = 0; i <= len; i++) check({tag, "_ram"}, 32'(mem[i]), 32'(exp_ram[i]));
   endtask

   initial begin
      int wait_cyc;
      arst_n_i = 1'b0;
      start_i  = 1'b0;
      len_i    = '0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
      repeat (2) @(negedge clk_i);
      check("reset_busy", 32'(busy_o), 32'd0);
      check("reset_done", 32'(sort_done_o), 32'd0);
      check("reset_rd_en", 32'(rd_en_o), 32'd0);
      check("reset_wr_en", 32'(wr_en_o), 32'd0);
      arst_n_i = 1'b1;
      @(negedge clk_i);

      load4(8'd1, 8'd2, 8'd3, 8'd4);
      run_sort(3, 1'b0, "sorted4");

      load4(8'd4, 8'd3, 8'd2, 8'd1);
      run_sort(3, 1'b0, "reverse4");

      load4(8'd9, 8'd7, 8'd0, 8'd0);
      run_sort(0, 1'b0, "len0");

      load4(8'd5, 8'd5, 8'd0, 8'd0);
      run_sort(1, 1'b0, "equal2");

      load4(8'hFF, 8'h00, 8'h80, 8'h7F);
      run_sort(3, 1'b0, "extremes");

      load4(8'd3, 8'd1, 8'd4, 8'd1);
      run_sort(3, 1'b1, "start_ignored");

      @(negedge clk_i);
      for (int i = 0; i < N; i++) mem[i] <= 8'($urandom_range(0, 255));
      @(negedge clk_i);
      run_sort(N - 1, 1'b0, "random16");

      // Abort in WR_A, before the first write commits.
      load4(8'd4, 8'd3, 8'd2, 8'd1);
      model(3);
      @(negedge clk_i);
      start_i = 1'b1;
      len_i   = 4'd3;
      @(negedge clk_i);
      start_i  = 1'b0;
      wait_cyc = 0;
      while (!wr_en_o && wait_cyc < 100) begin
         @(negedge clk_i);
         wait_cyc++;
      end
      check("abort_reached_wr_a", 32'(wr_en_o), 32'd1);
      #2 arst_n_i = 1'b0;
      #1;
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_wr_en", 32'(wr_en_o), 32'd0);
      check("abort_wr_data", 32'(wr_data_o), 32'd0);
      check("abort_rd_en", 32'(rd_en_o), 32'd0);
      check("abort_done", 32'(sort_done_o), 32'd0);
      wq.delete();
      lat_q.delete();
      @(negedge clk_i);
      arst_n_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         check("abort_no_done", 32'(sort_done_o | busy_o), 32'd0);
      end
      run_sort(3, 1'b0, "after_abort");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
